// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and default width for alu_seq
package alu_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_SHR = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;
   localparam logic [3:0] OP_DIV = 4'd9;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV
   } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - start/done request bus between operand muxes and alu_seq
interface alu_seq_if
   import alu_pkg::*;
   #(parameter int WIDTH = DEFAULT_WIDTH);

   logic             start;
   logic [3:0]       aluop;
   logic [WIDTH-1:0] srca;
   logic [WIDTH-1:0] srcb;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             zero;
   logic             carry;
   logic             neg;
   logic             ovf;
   logic             div_zero;
   logic             busy;
   logic             done;

   modport master (
      output start, aluop, srca, srcb,
      input  result, result_hi, zero, carry, neg, ovf, div_zero, busy, done
   );

   modport slave (
      input  start, aluop, srca, srcb,
      output result, result_hi, zero, carry, neg, ovf, div_zero, busy, done
   );

endinterface

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - one-bit-per-cycle shift-add multiply / restoring divide datapath
module muldiv_iter
   import alu_pkg::*;
   #(parameter int WIDTH = DEFAULT_WIDTH)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             last,
   output logic [WIDTH-1:0] lo_next,
   output logic [WIDTH-1:0] hi_next
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] opd;
   logic             div_mode;
   logic [CW-1:0]    count;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] trial;

   assign last = (count == CW'(WIDTH - 1));

   // MUL: hi:lo holds partial product with multiplier in lo; DIV: hi is remainder, lo shifts dividend out / quotient in
   always_comb begin
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
      shifted = {hi, lo[WIDTH-1]};
      trial   = {1'b0, shifted} - {2'b00, opd};
      lo_next = '0;
      hi_next = '0;
      if (div_mode) begin
         if (!trial[WIDTH+1]) begin
            hi_next = trial[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], 1'b1};
         end else begin
            hi_next = shifted[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         hi_next = sum[WIDTH:1];
         lo_next = {sum[0], lo[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi       <= '0;
         lo       <= '0;
         opd      <= '0;
         div_mode <= 1'b0;
         count    <= '0;
      end else if (load) begin
         hi       <= '0;
         lo       <= is_div ? a : b;
         opd      <= is_div ? b : a;
         div_mode <= is_div;
         count    <= '0;
      end else if (step) begin
         hi       <= hi_next;
         lo       <= lo_next;
         count    <= count + 1'b1;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - execution stage: single-cycle ALU ops plus iterative MUL/DIV behind start/done
module alu_seq
   import alu_pkg::*;
   #(parameter int WIDTH = DEFAULT_WIDTH)
(
   input  logic       clk,
   input  logic       rst_n,
   alu_seq_if.slave   bus
);

   localparam int SHW = $clog2(WIDTH);

   state_t state;
   state_t next_state;
   logic   load;
   logic   step;
   logic   last;

   logic [WIDTH-1:0] lo_next;
   logic [WIDTH-1:0] hi_next;

   logic [WIDTH:0]   sum_w;
   logic [WIDTH:0]   diff_w;
   logic [WIDTH:0]   shl_w;
   logic [WIDTH:0]   shr_w;
   logic [SHW-1:0]   amt;

   logic [WIDTH-1:0] sc_res;
   logic [WIDTH-1:0] sc_hi;
   logic             sc_carry;
   logic             sc_ovf;
   logic             sc_dz;

   logic [WIDTH-1:0] result_r;
   logic [WIDTH-1:0] result_hi_r;
   logic             zero_r;
   logic             carry_r;
   logic             neg_r;
   logic             ovf_r;
   logic             div_zero_r;
   logic             busy_r;
   logic             done_r;

   muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .step    (step),
      .is_div  (bus.aluop == OP_DIV),
      .a       (bus.srca),
      .b       (bus.srcb),
      .last    (last),
      .lo_next (lo_next),
      .hi_next (hi_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   // DIV by zero never enters S_DIV; it is answered like a single-cycle op
   always_comb begin
      next_state = state;
      load       = 1'b0;
      step       = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.aluop == OP_MUL) begin
                  next_state = S_MUL;
                  load       = 1'b1;
               end else if (bus.aluop == OP_DIV && bus.srcb != '0) begin
                  next_state = S_DIV;
                  load       = 1'b1;
               end
            end
         end
         S_MUL, S_DIV: begin
            step = 1'b1;
            if (last) next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   assign amt    = bus.srcb[SHW-1:0];
   assign sum_w  = {1'b0, bus.srca} + {1'b0, bus.srcb};
   assign diff_w = {1'b0, bus.srca} - {1'b0, bus.srcb};
   assign shl_w  = {1'b0, bus.srca} << amt;
   assign shr_w  = {bus.srca, 1'b0} >> amt;

   always_comb begin
      sc_res   = '0;
      sc_hi    = '0;
      sc_carry = 1'b0;
      sc_ovf   = 1'b0;
      sc_dz    = 1'b0;
      case (bus.aluop)
         OP_ADD: begin
            sc_res   = sum_w[WIDTH-1:0];
            sc_carry = sum_w[WIDTH];
            sc_ovf   = (bus.srca[WIDTH-1] == bus.srcb[WIDTH-1]) &&
                       (sum_w[WIDTH-1] != bus.srca[WIDTH-1]);
         end
         OP_SUB: begin
            sc_res   = diff_w[WIDTH-1:0];
            sc_carry = diff_w[WIDTH];
            sc_ovf   = (bus.srca[WIDTH-1] != bus.srcb[WIDTH-1]) &&
                       (diff_w[WIDTH-1] != bus.srca[WIDTH-1]);
         end
         OP_AND: sc_res = bus.srca & bus.srcb;
         OP_OR:  sc_res = bus.srca | bus.srcb;
         OP_XOR: sc_res = bus.srca ^ bus.srcb;
         OP_NOT: sc_res = ~bus.srca;
         OP_SHL: begin
            sc_res   = shl_w[WIDTH-1:0];
            sc_carry = shl_w[WIDTH];
         end
         OP_SHR: begin
            sc_res   = shr_w[WIDTH:1];
            sc_carry = shr_w[0];
         end
         OP_DIV: begin
            sc_res = '1;
            sc_hi  = bus.srca;
            sc_dz  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_r    <= '0;
         result_hi_r <= '0;
         zero_r      <= 1'b0;
         carry_r     <= 1'b0;
         neg_r       <= 1'b0;
         ovf_r       <= 1'b0;
         div_zero_r  <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         busy_r <= (next_state != S_IDLE);
         if (state == S_IDLE && bus.start && !load) begin
            result_r    <= sc_res;
            result_hi_r <= sc_hi;
            zero_r      <= (sc_res == '0);
            carry_r     <= sc_carry;
            neg_r       <= sc_res[WIDTH-1];
            ovf_r       <= sc_ovf;
            div_zero_r  <= sc_dz;
            done_r      <= 1'b1;
         end else if (step && last) begin
            result_r    <= lo_next;
            result_hi_r <= hi_next;
            zero_r      <= (lo_next == '0);
            carry_r     <= (state == S_MUL) && (hi_next != '0);
            neg_r       <= lo_next[WIDTH-1];
            ovf_r       <= 1'b0;
            div_zero_r  <= 1'b0;
            done_r      <= 1'b1;
         end
      end
   end

   assign bus.result    = result_r;
   assign bus.result_hi = result_hi_r;
   assign bus.zero      = zero_r;
   assign bus.carry     = carry_r;
   assign bus.neg       = neg_r;
   assign bus.ovf       = ovf_r;
   assign bus.div_zero  = div_zero_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
module tb_alu_seq;
   import alu_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   lat;
   int   bcnt;
   int   extra;

   alu_seq_if bus ();

   alu_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] flags();
      return {bus.zero, bus.carry, bus.neg, bus.ovf, bus.div_zero};
   endfunction

   function automatic logic [31:0] all_outs();
      return {9'd0, bus.result, bus.result_hi, bus.zero, bus.carry, bus.neg,
              bus.ovf, bus.div_zero, bus.busy, bus.done};
   endfunction

   // returns edges after the sampling edge until done, and busy cycles seen
   task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int l, output int bc);
      bus.aluop = op;
      bus.srca  = a;
      bus.srcb  = b;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      l  = 0;
      bc = bus.busy ? 1 : 0;
      while (!bus.done && l < 20) begin
         @(posedge clk);
         #1;
         l++;
         if (bus.busy && !bus.done) bc++;
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.aluop = 4'd0;
      bus.srca  = 8'd0;
      bus.srcb  = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", all_outs(), 32'd0);
      rst_n = 1'b1;

      // reset in the middle of a MUL
      bus.aluop = OP_MUL; bus.srca = 8'hC8; bus.srcb = 8'h0A; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("mid_mul_busy", {31'd0, bus.busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_mul_reset_outputs", all_outs(), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      extra = 0;
      repeat (10) begin @(posedge clk); #1; if (bus.done) extra++; end
      chk("no_done_after_abort", extra, 0);

      run_op(OP_ADD, 8'd1, 8'd2, lat, bcnt);
      chk("add_1_2_latency", lat, 0);
      chk("add_1_2_result", {24'd0, bus.result}, 32'h03);

      run_op(OP_ADD, 8'hFF, 8'h01, lat, bcnt);
      chk("add_ff_01_result", {24'd0, bus.result}, 32'h00);
      chk("add_ff_01_flags", {27'd0, flags()}, 32'b11000);

      run_op(OP_ADD, 8'h7F, 8'h01, lat, bcnt);
      chk("add_7f_01_result", {24'd0, bus.result}, 32'h80);
      chk("add_7f_01_flags", {27'd0, flags()}, 32'b00110);

      run_op(OP_MUL, 8'hC8, 8'h0A, lat, bcnt);
      chk("mul_latency", lat, 8);
      chk("mul_busy_cycles", bcnt, 8);
      chk("mul_busy_at_done", {31'd0, bus.busy}, 32'd0);
      chk("mul_result", {16'd0, bus.result_hi, bus.result}, 32'h07D0);
      chk("mul_flags", {27'd0, flags()}, 32'b01100);

      run_op(OP_DIV, 8'hC8, 8'h07, lat, bcnt);
      chk("div_latency", lat, 8);
      chk("div_busy_cycles", bcnt, 8);
      chk("div_result", {16'd0, bus.result_hi, bus.result}, 32'h041C);
      chk("div_flags", {27'd0, flags()}, 32'b00000);
      repeat (2) begin @(posedge clk); #1; end
      chk("div_hold", {23'd0, bus.done, bus.result}, 32'h01C);

      run_op(OP_DIV, 8'h05, 8'h00, lat, bcnt);
      chk("div0_latency", lat, 0);
      chk("div0_busy_cycles", bcnt, 0);
      chk("div0_result", {16'd0, bus.result_hi, bus.result}, 32'h05FF);
      chk("div0_flags", {27'd0, flags()}, 32'b00101);

      run_op(4'd12, 8'h33, 8'h44, lat, bcnt);
      chk("illegal_latency", lat, 0);
      chk("illegal_result", {16'd0, bus.result_hi, bus.result}, 32'h0000);
      chk("illegal_flags", {27'd0, flags()}, 32'b10000);

      // start held high with changing operands while a MUL runs
      bus.aluop = OP_MUL; bus.srca = 8'h03; bus.srcb = 8'h04; bus.start = 1'b1;
      @(posedge clk);
      #1;
      lat = 0;
      while (!bus.done && lat < 20) begin
         bus.aluop = 4'(lat);
         bus.srca  = 8'(lat * 17 + 5);
         bus.srcb  = 8'(8'hF0 - lat);
         @(posedge clk);
         #1;
         lat++;
      end
      bus.start = 1'b0;
      chk("held_start_latency", lat, 8);
      chk("held_start_result", {16'd0, bus.result_hi, bus.result}, 32'h000C);
      extra = 0;
      repeat (4) begin @(posedge clk); #1; if (bus.done) extra++; end
      chk("held_start_single_done", extra, 0);

      // SUB issued in the done cycle of a MUL
      run_op(OP_MUL, 8'h02, 8'h03, lat, bcnt);
      chk("b2b_mul_result", {16'd0, bus.result_hi, bus.result}, 32'h0006);
      bus.aluop = OP_SUB; bus.srca = 8'h03; bus.srcb = 8'h05; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk("b2b_sub_done", {30'd0, bus.done, bus.busy}, 32'b10);
      chk("b2b_sub_result", {16'd0, bus.result_hi, bus.result}, 32'h00FE);
      chk("b2b_sub_flags", {27'd0, flags()}, 32'b01100);

      run_op(OP_SHL, 8'h81, 8'h01, lat, bcnt);
      chk("shl_latency", lat, 0);
      chk("shl_result", {24'd0, bus.result}, 32'h02);
      chk("shl_flags", {27'd0, flags()}, 32'b01000);

      run_op(OP_SHR, 8'h81, 8'h00, lat, bcnt);
      chk("shr_result", {24'd0, bus.result}, 32'h81);
      chk("shr_flags", {27'd0, flags()}, 32'b00100);

      @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
